// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package if_fetch_unit_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [XLEN-1:0] WORD_INC = 32'd4;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_FULL = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_id_reg.sv
// IF/ID output register: instruction, its PC and PC+4 with a valid flag.
module if_id_reg
   import if_fetch_unit_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            clear,
   input  logic [XLEN-1:0] next_instr,
   input  logic [XLEN-1:0] next_pc,
   input  logic [XLEN-1:0] next_pc_add4,
   output logic            valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_add4
);

   // Load wins over clear; payload holds when cleared or stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid   <= 1'b0;
         instr   <= '0;
         pc      <= '0;
         pc_add4 <= '0;
      end else if (load) begin
         valid   <= 1'b1;
         instr   <= next_instr;
         pc      <= next_pc;
         pc_add4 <= next_pc_add4;
      end else if (clear) begin
         valid   <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC register, single-outstanding imem handshake,
// delay-slot aware redirect, and the IF/ID output register.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_add4,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] req_pc_q;
   logic [XLEN-1:0] target_q;
   logic            outstanding_q;
   logic            redirect_pending_q;

   logic            req_c;
   logic            load_c;
   logic            accept_c;
   logic            redirect_c;
   logic            issue_c;

   assign accept_c   = id_valid & id_ready;
   assign redirect_c = accept_c & br_taken;
   assign issue_c    = req_c & imem_gnt;
   assign imem_req   = req_c;
   assign imem_addr  = pc_q;

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_REQ;
      else        state_q <= state_d;
   end

   // Next state, request qualification and response load.
   always_comb begin
      state_d = state_q;
      req_c   = 1'b0;
      load_c  = 1'b0;
      unique case (state_q)
         S_REQ: begin
            req_c = !id_valid || id_ready;
            if (req_c && imem_gnt)         state_d = S_WAIT;
            else if (id_valid && !id_ready) state_d = S_FULL;
         end
         S_WAIT: begin
            if (imem_rvalid && outstanding_q) begin
               load_c  = 1'b1;
               state_d = S_REQ;
            end
         end
         S_FULL: begin
            req_c = id_ready;
            if (id_ready) state_d = imem_gnt ? S_WAIT : S_REQ;
         end
         default: state_d = S_REQ;
      endcase
      // No request may be presented while held in reset.
      req_c = req_c & reset;
   end

   // PC advance on issue; a redirect that misses its delay-slot issue is parked.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q               <= RESET_PC;
         req_pc_q           <= '0;
         target_q           <= '0;
         outstanding_q      <= 1'b0;
         redirect_pending_q <= 1'b0;
      end else begin
         if (issue_c) begin
            req_pc_q      <= pc_q;
            outstanding_q <= 1'b1;
            if (redirect_c)              pc_q <= br_target;
            else if (redirect_pending_q) pc_q <= target_q;
            else                         pc_q <= pc_q + WORD_INC;
            redirect_pending_q <= 1'b0;
         end else if (redirect_c) begin
            target_q           <= br_target;
            redirect_pending_q <= 1'b1;
         end
         if (load_c) outstanding_q <= 1'b0;
      end
   end

   if_id_reg u_if_id_reg (
      .clk          (clk),
      .reset        (reset),
      .load         (load_c),
      .clear        (accept_c),
      .next_instr   (imem_rdata),
      .next_pc      (req_pc_q),
      .next_pc_add4 (req_pc_q + WORD_INC),
      .valid        (id_valid),
      .instr        (id_instr),
      .pc           (id_pc),
      .pc_add4      (id_pc_add4)
   );

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the inputs consumed by the ID-stage next-PC logic: fetched instruction, its PC, and PC+4.
- Consumes the resolved next-PC target back from ID, with MIPS single-delay-slot semantics.
- Owns the PC register, a single-outstanding instruction-memory request/response handshake, and the IF/ID output register with valid/ready flow control.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state while low.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  word-aligned fetch address, valid with imem_req.
- imem_gnt  input  1  memory accepts request this cycle (req & gnt = issue).
- imem_rvalid  input  1  response data valid; exactly one per issued request, at least 1 cycle after issue.
- imem_rdata  input  32  fetched instruction.
- id_valid  output  1  IF/ID register holds a valid instruction.
- id_ready  input  1  ID consumes the instruction this cycle (valid & ready = accept).
- id_instr  output  32  instruction to ID.
- id_pc  output  32  PC of id_instr.
- id_pc_add4  output  32  id_pc + 4.
- br_taken  input  1  qualified by accept: the instruction being accepted redirects control flow (taken branch, j, jal, jr, jalr).
- br_target  input  32  redirect target, valid with br_taken.

Behaviour:
- Reset values (reset low):
  - pc_q = RESET_PC; imem_req = 0; id_valid = 0; id_instr/id_pc/id_pc_add4 = 0.
  - outstanding = 0; redirect_pending = 0; FSM = REQ.
  - The first imem_req is asserted in the first cycle after reset deasserts.
- FSM states:
  - REQ: imem_req = 1 when the output register is empty or being accepted this cycle. On gnt: record req_pc = pc_q, advance pc_q, go to WAIT.
  - WAIT: imem_req = 0. On rvalid: load id_instr = rdata, id_pc = req_pc, id_pc_add4 = req_pc + 4, id_valid = 1, go to REQ.
  - FULL: id_valid = 1 and not accepted. No request issued. On accept, go to REQ; the request may issue in that same cycle.
- Single outstanding request. A response always has a free output register, guaranteed by the issue condition.
- pc_q advance on issue:
  - if a redirect is pending, or arrives in the same cycle as the issue: pc_q <= br_target (or the held target); clear pending.
  - else pc_q <= pc_q + 4.
  - All adds are 32-bit modulo; 0xFFFF_FFFC + 4 wraps to 0.
- Delay slot:
  - When a branch is accepted with br_taken = 1, its delay slot (branch PC + 4) has not yet been issued. It is either issued in the same cycle or still in pc_q.
  - The delay slot is always fetched and delivered. The request after it uses br_target.
  - If the delay-slot issue is later than the accept cycle: latch br_target into a target register and set redirect_pending.
- Redirect with no taken branch: br_taken is ignored when id_valid & id_ready is 0.
- Simultaneous response and accept in WAIT: cannot occur, since id_valid = 0 in WAIT.
- Simultaneous accept and issue in REQ/FULL→REQ:
  - the output register frees and the request issues in the same cycle;
  - throughput is one instruction per 2 cycles at best (issue, response); acceptable.
- Output stability: id_instr, id_pc, id_pc_add4 hold stable while id_valid & !id_ready.
- imem_req/imem_addr hold stable until gnt once asserted; imem_addr = pc_q.
- Reset mid-operation: all state clears immediately. A response arriving after reset release with no recorded outstanding request is ignored.

Decomposition:
- Shared package (constants):
  - RESET_PC default;
  - FSM state encoding REQ/WAIT/FULL (2-bit);
  - WORD_INC = 32'd4.
- Sub-module if_id_reg: the 32+32+32-bit output register with valid flag, load and clear, async active-low reset. All remaining logic lives in the top.

Test Plan:
- Reset and straight-line fetch:
  - Stimulus: release reset; imem_gnt = 1 always; rvalid 1 cycle after issue; id_ready = 1.
  - Response: addresses 0x3000, 0x3004, 0x3008 in order; id_pc_add4 = id_pc + 4 on each.
- Taken branch, same-cycle delay-slot issue:
  - Stimulus: the instruction at 0x3010 is accepted with br_taken = 1, br_target = 0x3100.
  - Response: fetch order is 0x3014 (delay slot, delivered), then 0x3100, 0x3104.
- Taken branch with memory backpressure:
  - Stimulus: imem_gnt held 0 for 3 cycles across the accept of a branch at 0x3020 (target 0x3400).
  - Response: imem_addr = 0x3024 until gnt; next request is 0x3400; no address skipped or repeated.
- ID stall:
  - Stimulus: id_ready = 0 for 5 cycles with id_valid = 1.
  - Response: outputs stable; no imem_req; after id_ready = 1, next request issues the same cycle.
- Wrap-around:
  - Stimulus: redirect to 0xFFFF_FFFC.
  - Response: next sequential fetch is 0x0000_0000; id_pc_add4 of 0xFFFF_FFFC = 0.
- Reset mid-fetch:
  - Stimulus: assert reset while in WAIT, then drive a stray rvalid after release.
  - Response: id_valid = 0; stray data ignored; first request after release is RESET_PC.
